// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: emits a commanded number of A/B edges, one every
// cmd_interval clocks, in the commanded direction. The phase carries over between commands.
module quadrature_encoder_emulator #(
    parameter int unsigned EDGE_COUNT_RESOLUTION = 16,
    parameter int unsigned INTERVAL_WIDTH        = 24
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [EDGE_COUNT_RESOLUTION-1:0] cmd_edges,
    input  logic [INTERVAL_WIDTH-1:0]        cmd_interval,
    input  logic                             cmd_dir,
    input  logic                             abort,
    output logic                             tach_a,
    output logic                             tach_b,
    output logic                             busy,
    output logic                             done,
    output logic [EDGE_COUNT_RESOLUTION-1:0] edges_emitted
);

    localparam int unsigned EW = EDGE_COUNT_RESOLUTION;
    localparam int unsigned IW = INTERVAL_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] target_q, target_d;
    logic [EW-1:0] emitted_q, emitted_d;
    logic [IW-1:0] interval_q, interval_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [1:0]    phase_q, phase_d;
    logic          tach_a_q, tach_a_d;
    logic          tach_b_q, tach_b_d;
    logic          done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            target_q   <= '0;
            emitted_q  <= '0;
            interval_q <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            phase_q    <= 2'd0;
            tach_a_q   <= 1'b0;
            tach_b_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            emitted_q  <= emitted_d;
            interval_q <= interval_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            phase_q    <= phase_d;
            tach_a_q   <= tach_a_d;
            tach_b_q   <= tach_b_d;
            done_q     <= done_d;
        end
    end

    // Next-state: accept in IDLE, pace edges in RUN; abort takes priority over an edge
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        emitted_d  = emitted_q;
        interval_d = interval_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            if (cmd_valid) begin
                target_d   = cmd_edges;
                interval_d = (cmd_interval == '0) ? IW'(1) : cmd_interval;
                dir_d      = cmd_dir;
                cnt_d      = '0;
                emitted_d  = '0;
                if (cmd_edges == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
        end else begin
            if (abort) begin
                state_d = IDLE;
            end else if (cnt_q == interval_q - IW'(1)) begin
                cnt_d     = '0;
                phase_d   = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
                emitted_d = emitted_q + EW'(1);
                if (emitted_q == target_q - EW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end

        // Gray mapping p0:00 p1:10 p2:11 p3:01, registered so A/B never glitch
        tach_a_d = phase_d[0] ^ phase_d[1];
        tach_b_d = phase_d[1];
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q == RUN);
    assign tach_a        = tach_a_q;
    assign tach_b        = tach_b_q;
    assign done          = done_q;
    assign edges_emitted = emitted_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Directed bench for quadrature_encoder_emulator: a per-cycle phase model plus
// hand-computed end-of-command expectations.
module tb_quadrature_encoder_emulator;

    localparam int unsigned EW = 8;
    localparam int unsigned IW = 8;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [EW-1:0] cmd_edges;
    logic [IW-1:0] cmd_interval;
    logic          cmd_dir;
    logic          abort;
    logic          tach_a;
    logic          tach_b;
    logic          busy;
    logic          done;
    logic [EW-1:0] edges_emitted;

    int checks = 0;
    int errors = 0;
    logic [1:0] mp = 2'd0;

    quadrature_encoder_emulator #(
        .EDGE_COUNT_RESOLUTION(EW),
        .INTERVAL_WIDTH       (IW)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_edges    (cmd_edges),
        .cmd_interval (cmd_interval),
        .cmd_dir      (cmd_dir),
        .abort        (abort),
        .tach_a       (tach_a),
        .tach_b       (tach_b),
        .busy         (busy),
        .done         (done),
        .edges_emitted(edges_emitted)
    );

    always #4 clk_in = ~clk_in;

    function automatic logic [1:0] ab_of(input logic [1:0] p);
        case (p)
            2'd0:    ab_of = 2'b00;
            2'd1:    ab_of = 2'b10;
            2'd2:    ab_of = 2'b11;
            default: ab_of = 2'b01;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one command, checking every cycle against the phase model.
    task automatic run_cmd(input int n, input int iv, input bit dir, input int abort_at,
                           input bit abort_on_accept, input bit noise);
        int ivf;
        int exp_e;
        bit edge_now;
        ivf   = (iv == 0) ? 1 : iv;
        exp_e = 0;
        cmd_valid    = 1'b1;
        cmd_edges    = EW'(n);
        cmd_interval = IW'(iv);
        cmd_dir      = dir;
        abort        = abort_on_accept;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        if (n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_ready", 32'(cmd_ready), 32'd1);
            chk("zero_edges", 32'(edges_emitted), 32'd0);
            chk("zero_ab", 32'({tach_a, tach_b}), 32'(ab_of(mp)));
            step();
            chk("zero_done_clr", 32'(done), 32'd0);
            return;
        end
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_ready", 32'(cmd_ready), 32'd0);
        chk("acc_edges", 32'(edges_emitted), 32'd0);
        if (noise) begin
            cmd_valid    = 1'b1;
            cmd_edges    = EW'(1);
            cmd_interval = IW'(1);
            cmd_dir      = ~dir;
        end
        for (int c = 1; c <= n * ivf + 5; c++) begin
            if (c == abort_at) abort = 1'b1;
            step();
            abort = 1'b0;
            if (c == abort_at) begin
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(cmd_ready), 32'd1);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_edges", 32'(edges_emitted), 32'(exp_e));
                chk("abort_ab", 32'({tach_a, tach_b}), 32'(ab_of(mp)));
                cmd_valid = 1'b0;
                step();
                chk("abort_hold_ab", 32'({tach_a, tach_b}), 32'(ab_of(mp)));
                chk("abort_hold_done", 32'(done), 32'd0);
                return;
            end
            edge_now = (c % ivf) == 0;
            if (edge_now) begin
                exp_e++;
                mp = dir ? mp - 2'd1 : mp + 2'd1;
            end
            chk("run_ab", 32'({tach_a, tach_b}), 32'(ab_of(mp)));
            chk("run_edges", 32'(edges_emitted), 32'(exp_e));
            chk("run_done", 32'(done), 32'(exp_e == n && edge_now));
            chk("run_busy", 32'(busy), 32'(exp_e != n));
            if (exp_e == n) begin
                cmd_valid = 1'b0;
                chk("end_ready", 32'(cmd_ready), 32'd1);
                step();
                chk("end_done_clr", 32'(done), 32'd0);
                return;
            end
        end
        cmd_valid = 1'b0;
        chk("run_timeout", 32'(exp_e), 32'(n));
    endtask

    initial begin
        reset_in     = 1'b1;
        cmd_valid    = 1'b0;
        cmd_edges    = '0;
        cmd_interval = '0;
        cmd_dir      = 1'b0;
        abort        = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ab", 32'({tach_a, tach_b}), 32'd0);
        chk("rst_edges", 32'(edges_emitted), 32'd0);
        reset_in = 1'b0;
        step();

        // Forward 8 edges, interval 4: ends at phase 0
        run_cmd(8, 4, 1'b0, -1, 1'b0, 1'b0);
        chk("fwd_final_ab", 32'({tach_a, tach_b}), 32'b00);
        chk("fwd_final_edges", 32'(edges_emitted), 32'd8);

        // Reverse 3 edges back to back: 01,11,10
        run_cmd(3, 1, 1'b1, -1, 1'b0, 1'b0);
        chk("rev_final_ab", 32'({tach_a, tach_b}), 32'b10);
        chk("rev_final_edges", 32'(edges_emitted), 32'd3);

        // Zero edges, then interval 0 treated as 1
        run_cmd(0, 5, 1'b0, -1, 1'b0, 1'b0);
        chk("zero_final_ab", 32'({tach_a, tach_b}), 32'b10);
        run_cmd(2, 0, 1'b0, -1, 1'b0, 1'b0);
        chk("iv0_final_ab", 32'({tach_a, tach_b}), 32'b01);
        chk("iv0_final_edges", 32'(edges_emitted), 32'd2);

        // Aborts with cmd_valid noise while running
        run_cmd(100, 10, 1'b0, 55, 1'b0, 1'b1);
        chk("abort55_ab", 32'({tach_a, tach_b}), 32'b00);
        chk("abort55_edges", 32'(edges_emitted), 32'd5);
        run_cmd(100, 10, 1'b0, 60, 1'b0, 1'b1);
        chk("abort60_ab", 32'({tach_a, tach_b}), 32'b10);
        chk("abort60_edges", 32'(edges_emitted), 32'd5);

        // Abort is ignored while idle, including on the accept cycle
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_edges", 32'(edges_emitted), 32'd5);
        run_cmd(2, 1, 1'b0, -1, 1'b1, 1'b0);
        chk("acc_abort_ab", 32'({tach_a, tach_b}), 32'b01);

        // Four consecutive commands: continuous phase, net +40 edges
        run_cmd(20, 5, 1'b0, -1, 1'b0, 1'b0);
        run_cmd(20, 5, 1'b0, -1, 1'b0, 1'b0);
        run_cmd(20, 5, 1'b1, -1, 1'b0, 1'b0);
        run_cmd(20, 5, 1'b0, -1, 1'b0, 1'b0);
        chk("loop_final_ab", 32'({tach_a, tach_b}), 32'b01);

        // Full-range edge count without wrap
        run_cmd(255, 1, 1'b0, -1, 1'b0, 1'b0);
        chk("max_final_edges", 32'(edges_emitted), 32'hFF);
        chk("max_final_ab", 32'({tach_a, tach_b}), 32'b11);

        // Reset mid-run at edge 3 of 10
        cmd_valid    = 1'b1;
        cmd_edges    = EW'(10);
        cmd_interval = IW'(2);
        cmd_dir      = 1'b0;
        step();
        cmd_valid = 1'b0;
        repeat (6) step();
        chk("pre_rst_edges", 32'(edges_emitted), 32'd3);
        chk("pre_rst_ab", 32'({tach_a, tach_b}), 32'b10);
        reset_in = 1'b1;
        #1;
        chk("mid_rst_ab", 32'({tach_a, tach_b}), 32'b00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_edges", 32'(edges_emitted), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_done", 32'(done), 32'd0);
        end
        reset_in = 1'b0;
        mp = 2'd0;
        step();
        chk("post_rst_done", 32'(done), 32'd0);
        run_cmd(2, 3, 1'b1, -1, 1'b0, 1'b0);
        chk("post_rst_ab", 32'({tach_a, tach_b}), 32'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quadrature_encoder_emulator.md
QUADRATURE_ENCODER_EMULATOR -- requirements
Module: quadrature_encoder_emulator

Interface
REQ-001 SHALL have parameter EDGE_COUNT_RESOLUTION, default 16, width of edge-count command and status.
REQ-002 SHALL have parameter INTERVAL_WIDTH, default 24, width of edge-interval command (clk_in cycles).
REQ-003 SHALL have port clk_in  input  1  clock (125 MHz).
REQ-004 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at posedge.
REQ-007 SHALL have port cmd_edges  input  EDGE_COUNT_RESOLUTION  number of edges to emit.
REQ-008 SHALL have port cmd_interval  input  INTERVAL_WIDTH  clk_in cycles between successive edges.
REQ-009 SHALL have port cmd_dir  input  1  0 = forward (A leads B), 1 = reverse (B leads A).
REQ-010 SHALL have port abort  input  1  terminate running command.
REQ-011 SHALL have port tach_a  output  1  quadrature channel A.
REQ-012 SHALL have port tach_b  output  1  quadrature channel B.
REQ-013 SHALL have port busy  output  1  high while a command runs.
REQ-014 SHALL have port done  output  1  one-cycle pulse on normal command completion.
REQ-015 SHALL have port edges_emitted  output  EDGE_COUNT_RESOLUTION  edges emitted by current/last command.

Function
REQ-016 SHALL implement states IDLE and RUN; cmd_ready = (state==IDLE), busy = (state==RUN), both registered-state-derived, no combinational path from cmd_valid.
REQ-017 SHALL, on accept, latch cmd_edges, cmd_interval, cmd_dir, clear edges_emitted and the interval counter, and enter RUN.
REQ-018 SHALL treat cmd_interval==0 as 1.
REQ-019 SHALL, on accept with cmd_edges==0, stay IDLE, emit no edges, and pulse done in the following cycle.
REQ-020 SHALL keep a 2-bit phase p mapping (tach_a,tach_b) = p0:00, p1:10, p2:11, p3:01; forward p+1 mod 4, reverse p-1 mod 4; exactly one output toggles per edge.
REQ-021 SHALL retain phase across commands and aborts (no return to 00 except by reset).
REQ-022 SHALL, for accept at posedge t0 with interval I and N edges, produce edges at posedges t0+I, t0+2I, ..., t0+N*I, outputs registered (no glitches).
REQ-023 SHALL increment edges_emitted with each edge, visible same cycle as the output toggle.
REQ-024 SHALL, at the posedge producing edge N, assert done for exactly one cycle and return to IDLE (cmd_ready high in same cycle as done).
REQ-025 SHALL, on abort sampled high in RUN, return to IDLE without an edge that cycle, without done, holding tach_a/tach_b and edges_emitted; abort wins over a coincident edge; abort ignored in IDLE.
REQ-026 SHALL ignore cmd_valid and hold latched command while in RUN.
REQ-027 SHALL use the full unsigned EDGE_COUNT_RESOLUTION range for cmd_edges (max 2^N-1 edges) with no wrap of edges_emitted.

Reset
REQ-028 SHALL, while reset_in high, force state IDLE, tach_a=0, tach_b=0, phase 0, busy=0, done=0, edges_emitted=0, interval counter 0; cmd_ready=1.
REQ-029 SHALL, on reset_in asserted mid-RUN, abandon the command immediately without done.

Verification
REQ-030 Forward: cmd_edges=8, interval=4, dir=0 from reset -> (A,B) 10,11,01,00,10,11,01,00 at t0+4..t0+32, done single pulse at t0+32, edges_emitted=8.
REQ-031 Reverse: cmd_edges=3, interval=1, dir=1 starting phase 0 -> (A,B) 01,11,10 on three consecutive cycles, done with third edge.
REQ-032 Zero/degenerate: cmd_edges=0 -> no toggles, done one cycle later; cmd_interval=0, cmd_edges=2 -> edges at t0+1, t0+2.
REQ-033 Abort: cmd_edges=100, interval=10, abort at t0+55 -> 5 edges, no done, outputs held, cmd_ready=1 next cycle; abort coincident with edge at t0+60 -> still 5 edges.
REQ-034 Loopback with edge counter (1,250,000-cycle window): interval=125, cmd_edges=20000 -> counter reports 10000 per full window; 4 consecutive commands show continuous phase, no double toggle.
REQ-035 Reset mid-RUN at edge 3 of 10 -> outputs 00, busy 0, done never asserted, new command accepted after reset release.
